// File: rtl/bp_pkg.sv
// bp_pkg: shared types for the branch predictor.
// Holds the 2-bit counter encoding, the table entry layout and the
// saturating counter update used when a resolved branch trains an entry.
package bp_pkg;

    // 2-bit confidence counter: the MSB is the taken/not-taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } bp_state_t;

    // Widest tag any legal configuration can need (ENTRIES >= 4 leaves
    // at most 28 PC bits above the index). Unused upper bits stay 0.
    localparam int TAG_MAX_W = 28;

    localparam bp_state_t COUNTER_RESET = WNT;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [29:0]          target;   // word address, low 2 bits implied 00
        bp_state_t            counter;
    } bp_entry_t;

    // Saturating step toward the resolved outcome.
    function automatic bp_state_t sat_update(bp_state_t s, logic taken);
        bp_state_t r;
        r = s;
        if (taken) begin
            if (s != ST) r = bp_state_t'(s + 2'd1);
        end else begin
            if (s != SNT) r = bp_state_t'(s - 2'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/bp_table.sv
// bp_table: direct-mapped BTB + BHT storage.
// Two asynchronous read ports (fetch lookup and the training
// read-modify-write) and one synchronous write port. Valid bits and
// counters reset asynchronously; tags and targets are plain storage
// whose content is ignored while the valid bit is clear.
// A write is visible to readers only after the clock edge, so a
// same-cycle read of the written index returns the old contents.
module bp_table
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_f,
    output bp_entry_t        rd_entry_f,
    input  logic [IDX_W-1:0] rd_idx_d,
    output bp_entry_t        rd_entry_d,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  bp_entry_t        wr_entry
);

    logic                 valid_q   [ENTRIES];
    logic                 valid_d   [ENTRIES];
    bp_state_t            counter_q [ENTRIES];
    bp_state_t            counter_d [ENTRIES];
    logic [TAG_MAX_W-1:0] tag_q     [ENTRIES];
    logic [TAG_MAX_W-1:0] tag_d     [ENTRIES];
    logic [29:0]          target_q  [ENTRIES];
    logic [29:0]          target_d  [ENTRIES];

    // Next table contents: only the written entry changes.
    always_comb begin
        valid_d   = valid_q;
        counter_d = counter_q;
        tag_d     = tag_q;
        target_d  = target_q;
        if (wr_en) begin
            valid_d[wr_idx]   = wr_entry.valid;
            counter_d[wr_idx] = wr_entry.counter;
            tag_d[wr_idx]     = wr_entry.tag;
            target_d[wr_idx]  = wr_entry.target;
        end
    end

    // Valid bits and counters: async reset so a reset invalidates at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]   <= 1'b0;
                counter_q[i] <= COUNTER_RESET;
            end
        end else begin
            valid_q   <= valid_d;
            counter_q <= counter_d;
        end
    end

    // Tags and targets: no reset needed, guarded by the valid bit.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

    // Fetch-side lookup read.
    always_comb begin
        rd_entry_f         = '0;
        rd_entry_f.valid   = valid_q[rd_idx_f];
        rd_entry_f.tag     = tag_q[rd_idx_f];
        rd_entry_f.target  = target_q[rd_idx_f];
        rd_entry_f.counter = counter_q[rd_idx_f];
    end

    // Decode-side read feeding the training update.
    always_comb begin
        rd_entry_d         = '0;
        rd_entry_d.valid   = valid_q[rd_idx_d];
        rd_entry_d.tag     = tag_q[rd_idx_d];
        rd_entry_d.target  = target_q[rd_idx_d];
        rd_entry_d.counter = counter_q[rd_idx_d];
    end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: dynamic BTB + 2-bit BHT predictor beside fetch.
// F: combinational lookup of pc_f produces predict_pc / predict_taken_f.
// D: the prediction travels with the instruction; the resolved branch is
//    compared against it (predict_miss) and trains the table.
// Optional build macro BRANCH_PREDICTOR_STATS_EN adds the stat_branches
// and stat_misses counters as output ports.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic [31:0] pc_f,
    input  logic [31:0] pc_plus_4_f,
    input  logic        is_branch_d,
    input  logic        pc_src_d,
    input  logic [31:0] pc_branch_d,
`ifdef BRANCH_PREDICTOR_STATS_EN
    output logic [31:0] stat_branches,
    output logic [31:0] stat_misses,
`endif
    output logic [31:0] predict_pc,
    output logic        predict_taken_f,
    output logic        predict_miss,
    output logic [31:0] recover_pc_d
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_LO = IDX_W + 2;

    // ------------------------------------------------------------ F lookup
    logic [IDX_W-1:0]     idx_f;
    logic [TAG_MAX_W-1:0] tag_f;
    bp_entry_t            entry_f;
    logic                 hit_f;

    // Index/tag split of the fetch PC and hit/prediction decode.
    always_comb begin
        idx_f                = pc_f[IDX_W+1:2];
        tag_f                = '0;
        tag_f[TAG_W-1:0]     = pc_f[TAG_LO +: TAG_W];
        hit_f                = entry_f.valid && (entry_f.tag == tag_f);
        predict_taken_f      = hit_f && entry_f.counter[1];
        predict_pc           = predict_taken_f ? {entry_f.target, 2'b00} : pc_plus_4_f;
    end

    // ---------------------------------------------------------- D register
    logic        pred_taken_d_q, pred_taken_d_d;
    logic [31:0] pred_target_d_q, pred_target_d_d;
    logic [31:0] pc_d_q, pc_d_d;

    // Priority: stall_d holds, flush_d clears, stall_f inserts a bubble.
    always_comb begin
        pred_taken_d_d  = pred_taken_d_q;
        pred_target_d_d = pred_target_d_q;
        pc_d_d          = pc_d_q;
        if (stall_d) begin
            pred_taken_d_d  = pred_taken_d_q;
        end else if (flush_d || stall_f) begin
            pred_taken_d_d  = 1'b0;
            pred_target_d_d = '0;
            pc_d_d          = '0;
        end else begin
            pred_taken_d_d  = predict_taken_f;
            pred_target_d_d = predict_pc;
            pc_d_d          = pc_f;
        end
    end

    // D-stage prediction register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pred_taken_d_q  <= 1'b0;
            pred_target_d_q <= '0;
            pc_d_q          <= '0;
        end else begin
            pred_taken_d_q  <= pred_taken_d_d;
            pred_target_d_q <= pred_target_d_d;
            pc_d_q          <= pc_d_d;
        end
    end

    // ------------------------------------------------- miss and recovery
    logic train_d;

    // A branch misses on a wrong direction, or a taken branch whose
    // predicted target differs from the resolved one.
    always_comb begin
        train_d      = is_branch_d && !stall_d;
        predict_miss = train_d &&
                       ((pred_taken_d_q != pc_src_d) ||
                        (pc_src_d && (pred_target_d_q != pc_branch_d)));
        recover_pc_d = pc_src_d ? pc_branch_d : (pc_d_q + 32'd4);
    end

    // ------------------------------------------------------------ training
    logic [IDX_W-1:0]     idx_d;
    logic [TAG_MAX_W-1:0] tag_d;
    bp_entry_t            entry_d;
    bp_entry_t            wr_entry;
    logic                 hit_d;

    // Build the updated entry: step the counter on a hit, install on a miss.
    always_comb begin
        idx_d            = pc_d_q[IDX_W+1:2];
        tag_d            = '0;
        tag_d[TAG_W-1:0] = pc_d_q[TAG_LO +: TAG_W];
        hit_d            = entry_d.valid && (entry_d.tag == tag_d);
        wr_entry         = entry_d;
        if (hit_d) begin
            wr_entry.counter = sat_update(entry_d.counter, pc_src_d);
            if (pc_src_d) wr_entry.target = pc_branch_d[31:2];
        end else begin
            wr_entry.valid   = 1'b1;
            wr_entry.tag     = tag_d;
            wr_entry.counter = pc_src_d ? WT : WNT;
            wr_entry.target  = pc_src_d ? pc_branch_d[31:2] : 30'd0;
        end
    end

    bp_table #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_table (
        .clk        (clk),
        .rst        (reset),
        .rd_idx_f   (idx_f),
        .rd_entry_f (entry_f),
        .rd_idx_d   (idx_d),
        .rd_entry_d (entry_d),
        .wr_en      (train_d),
        .wr_idx     (idx_d),
        .wr_entry   (wr_entry)
    );

`ifdef BRANCH_PREDICTOR_STATS_EN
    // ----------------------------------------------------------- statistics
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_misses_q, stat_misses_d;

    // Count training edges and the mispredicted subset; both wrap.
    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_misses_d   = stat_misses_q;
        if (train_d) begin
            stat_branches_d = stat_branches_q + 32'd1;
            if (predict_miss) stat_misses_d = stat_misses_q + 32'd1;
        end
    end

    // Statistic counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_branches_q <= '0;
            stat_misses_q   <= '0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_misses_q   <= stat_misses_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_misses   = stat_misses_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed test of branch_predictor (ENTRIES=64, TAG_W=8).
// 0x0040_0020 and 0x0040_0120 share index 8 with tags 0x00 and 0x01.
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic [31:0] pc_f;
    logic [31:0] pc_plus_4_f;
    logic        is_branch_d;
    logic        pc_src_d;
    logic [31:0] pc_branch_d;
    logic [31:0] predict_pc;
    logic        predict_taken_f;
    logic        predict_miss;
    logic [31:0] recover_pc_d;
`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_misses;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] PC_A    = 32'h0040_0020;
    localparam logic [31:0] PC_B    = 32'h0040_0120;
    localparam logic [31:0] PC_FILL = 32'h0040_0010;
    localparam logic [31:0] TGT_A   = 32'h0040_0100;
    localparam logic [31:0] TGT_B   = 32'h0040_0200;

    branch_predictor #(
        .ENTRIES (64),
        .TAG_W   (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall_f         (stall_f),
        .stall_d         (stall_d),
        .flush_d         (flush_d),
        .pc_f            (pc_f),
        .pc_plus_4_f     (pc_plus_4_f),
        .is_branch_d     (is_branch_d),
        .pc_src_d        (pc_src_d),
        .pc_branch_d     (pc_branch_d),
`ifdef BRANCH_PREDICTOR_STATS_EN
        .stat_branches   (stat_branches),
        .stat_misses     (stat_misses),
`endif
        .predict_pc      (predict_pc),
        .predict_taken_f (predict_taken_f),
        .predict_miss    (predict_miss),
        .recover_pc_d    (recover_pc_d)
    );

    // Clock: 10 ns period, rising edge active.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present pc in F with no branch in D, check the lookup, clock it into D.
    task automatic fetch(input logic [31:0] pc, input logic exp_taken,
                         input logic [31:0] exp_pc, input string tag);
        pc_f        = pc;
        pc_plus_4_f = pc + 32'd4;
        is_branch_d = 1'b0;
        pc_src_d    = 1'b0;
        #1;
        chk({tag, "_taken"}, {31'd0, predict_taken_f}, {31'd0, exp_taken});
        chk({tag, "_pc"}, predict_pc, exp_pc);
        next_cycle();
    endtask

    // Resolve the branch held in D, check miss/recovery, train on the edge.
    task automatic resolve(input logic taken, input logic [31:0] tgt, input logic exp_miss,
                           input logic [31:0] exp_rec, input string tag);
        pc_f        = PC_FILL;
        pc_plus_4_f = PC_FILL + 32'd4;
        is_branch_d = 1'b1;
        pc_src_d    = taken;
        pc_branch_d = tgt;
        #1;
        chk({tag, "_miss"}, {31'd0, predict_miss}, {31'd0, exp_miss});
        chk({tag, "_recover"}, recover_pc_d, exp_rec);
        next_cycle();
        is_branch_d = 1'b0;
        pc_src_d    = 1'b0;
    endtask

    initial begin
        // ---------------------------------------------- reset state
        reset       = 1'b1;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        flush_d     = 1'b0;
        is_branch_d = 1'b0;
        pc_src_d    = 1'b0;
        pc_branch_d = '0;
        pc_f        = PC_FILL;
        pc_plus_4_f = PC_FILL + 32'd4;
        #3;
        chk("rst_taken", {31'd0, predict_taken_f}, 32'd0);
        chk("rst_pc", predict_pc, 32'h0040_0014);
        chk("rst_miss", {31'd0, predict_miss}, 32'd0);
        chk("rst_recover", recover_pc_d, 32'd4);
        repeat (2) @(posedge clk);
        #4 reset = 1'b0;
        next_cycle();

        // ------------------------------- cold branch at A, taken to 0x100
        fetch(PC_A, 1'b0, PC_A + 32'd4, "cold_a");
        // F reads index 8 in the same cycle D writes it: old contents seen.
        pc_f        = PC_A;
        pc_plus_4_f = PC_A + 32'd4;
        is_branch_d = 1'b1;
        pc_src_d    = 1'b1;
        pc_branch_d = TGT_A;
        #1;
        chk("cold_miss", {31'd0, predict_miss}, 32'd1);
        chk("cold_recover", recover_pc_d, TGT_A);
        chk("rw_same_idx_old", predict_pc, PC_A + 32'd4);
        next_cycle();
        is_branch_d = 1'b0;
        pc_src_d    = 1'b0;
        // Entry now WT -> taken, target 0x100. D holds A (pred not taken):
        // train nothing this cycle; fetch A again.
        fetch(PC_A, 1'b1, TGT_A, "warm_a1");
        resolve(1'b1, TGT_A, 1'b0, TGT_A, "a_taken2");           // WT -> ST
        fetch(PC_A, 1'b1, TGT_A, "warm_a2");
        resolve(1'b1, TGT_A, 1'b0, TGT_A, "a_taken3");           // ST stays
        fetch(PC_A, 1'b1, TGT_A, "warm_a3");
        resolve(1'b0, TGT_A, 1'b1, PC_A + 32'd4, "a_nt1");       // ST -> WT
        fetch(PC_A, 1'b1, TGT_A, "a_still_taken");
        resolve(1'b0, TGT_A, 1'b1, PC_A + 32'd4, "a_nt2");       // WT -> WNT
        fetch(PC_A, 1'b0, PC_A + 32'd4, "a_wnt");

        // ------------------------------------ tag conflict at index 8
        // D holds A; a non-branch in D never misses even if pc_src_d is 1.
        pc_f        = PC_B;
        pc_plus_4_f = PC_B + 32'd4;
        pc_src_d    = 1'b1;
        pc_branch_d = TGT_B;
        #1;
        chk("nonbranch_no_miss", {31'd0, predict_miss}, 32'd0);
        chk("b_cold_pc", predict_pc, PC_B + 32'd4);
        next_cycle();
        pc_src_d = 1'b0;
        resolve(1'b1, TGT_B, 1'b1, TGT_B, "b_install");          // B replaces A, WT
        fetch(PC_A, 1'b0, PC_A + 32'd4, "a_evicted");
        fetch(PC_B, 1'b1, TGT_B, "b_hit");

        // ------------------------------------------------ stall_d
        // D holds B predicted taken. Stall for one edge with a not-taken
        // resolution and a different PC in F: no miss, no training, no capture.
        stall_d     = 1'b1;
        is_branch_d = 1'b1;
        pc_src_d    = 1'b0;
        pc_f        = PC_FILL;
        pc_plus_4_f = PC_FILL + 32'd4;
        #1;
        chk("stall_no_miss", {31'd0, predict_miss}, 32'd0);
        next_cycle();
        stall_d = 1'b0;
        is_branch_d = 1'b0;
        resolve(1'b0, TGT_B, 1'b1, PC_B + 32'd4, "after_stall");  // WT -> WNT
        fetch(PC_B, 1'b0, PC_B + 32'd4, "b_wnt");
        resolve(1'b1, TGT_B, 1'b1, TGT_B, "b_retake");            // WNT -> WT
        fetch(PC_B, 1'b1, TGT_B, "b_wt_again");

        // ------------------------------------------------ flush_d
        // D holds B predicted taken; replace with a flushed fetch of B.
        flush_d     = 1'b1;
        pc_f        = PC_B;
        pc_plus_4_f = PC_B + 32'd4;
        next_cycle();
        flush_d = 1'b0;
        resolve(1'b0, TGT_B, 1'b0, 32'd4, "flushed");             // trains idx 0 only

        // ------------------------------------------------ stall_f bubble
        stall_f     = 1'b1;
        pc_f        = PC_B;
        pc_plus_4_f = PC_B + 32'd4;
        next_cycle();
        stall_f = 1'b0;
        pc_f    = PC_FILL;
        #1;
        chk("bubble_recover", recover_pc_d, 32'd4);
        chk("bubble_no_miss", {31'd0, predict_miss}, 32'd0);
        next_cycle();

`ifdef BRANCH_PREDICTOR_STATS_EN
        chk("stat_branches", stat_branches, 32'd9);
        chk("stat_misses", stat_misses, 32'd6);
`endif

        // ------------------------------------------ reset mid-stream
        pc_f        = PC_B;
        pc_plus_4_f = PC_B + 32'd4;
        #1;
        chk("pre_reset_b", predict_pc, TGT_B);
        #1 reset = 1'b1;
        #1;
        chk("reset_async_pc", predict_pc, PC_B + 32'd4);
`ifdef BRANCH_PREDICTOR_STATS_EN
        chk("reset_stat_branches", stat_branches, 32'd0);
        chk("reset_stat_misses", stat_misses, 32'd0);
`endif
        next_cycle();
        #2 reset = 1'b0;
        next_cycle();
        fetch(PC_A, 1'b0, PC_A + 32'd4, "post_reset_a");
        fetch(PC_B, 1'b0, PC_B + 32'd4, "post_reset_b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
